// File: rtl/pwm_pulse_decoder.sv
// Servo PWM receive decoder: measures high width and period of Pulse_In in
// microsecond ticks, recovers the 4-bit position code, checks the width and
// period windows and flags loss of signal.
module pwm_pulse_decoder #(
  parameter int unsigned TICK_DIV      = 100,
  parameter int unsigned POS_MIN_US    = 1000,
  parameter int unsigned POS_SHIFT     = 6,
  parameter int unsigned WMIN_US       = 500,
  parameter int unsigned WMAX_US       = 2500,
  parameter int unsigned PERIOD_MIN_US = 10000,
  parameter int unsigned PERIOD_MAX_US = 30000,
  parameter int unsigned TIMEOUT_US    = 40000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        Pulse_In,
  output logic [11:0] Width_us,
  output logic [15:0] Period_us,
  output logic [3:0]  Position,
  output logic        Valid,
  output logic        Width_Err,
  output logic        Period_Err,
  output logic        Lost
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     sync_q, sync_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [11:0]    wcnt_q, wcnt_d;
  logic [15:0]    pcnt_q, pcnt_d;
  logic [11:0]    wheld_q, wheld_d;
  logic [11:0]    width_q, width_d;
  logic [15:0]    period_q, period_d;
  logic [3:0]     pos_q, pos_d;
  logic           valid_q, valid_d;
  logic           werr_q, werr_d;
  logic           perr_q, perr_d;
  logic           lost_q, lost_d;

  logic           tick;
  logic [11:0]    wcnt_inc;
  logic [15:0]    pcnt_inc;
  logic           timeout;
  logic           werr_calc;
  logic           perr_calc;
  logic [11:0]    pos_diff;
  logic [11:0]    pos_shifted;
  logic [3:0]     pos_calc;

  // Input synchronizer, edge strobes, microsecond prescaler and saturating counters
  always_comb begin
    sync_d   = {sync_q[1:0], Pulse_In};
    rise_d   = sync_q[1] & ~sync_q[2];
    fall_d   = ~sync_q[1] & sync_q[2];
    tick     = (presc_q == PRESC_LAST);
    if (rise_q || tick) presc_d = '0;
    else                presc_d = presc_q + 1'b1;
    // The tick of the closing cycle is included so widths read floor(N/TICK_DIV)
    wcnt_inc = (tick && (wcnt_q != '1)) ? wcnt_q + 1'b1 : wcnt_q;
    pcnt_inc = (tick && (pcnt_q != '1)) ? pcnt_q + 1'b1 : pcnt_q;
    timeout  = (pcnt_inc >= 16'(TIMEOUT_US));
  end

  // Frame classification and position code from the held width
  always_comb begin
    werr_calc   = (wheld_q < 12'(WMIN_US)) || (wheld_q > 12'(WMAX_US));
    perr_calc   = (pcnt_inc < 16'(PERIOD_MIN_US)) || (pcnt_inc > 16'(PERIOD_MAX_US));
    pos_diff    = wheld_q - 12'(POS_MIN_US);
    pos_shifted = pos_diff >> POS_SHIFT;
    if (wheld_q < 12'(POS_MIN_US)) pos_calc = '0;
    else if (pos_shifted > 12'd15) pos_calc = '1;
    else                           pos_calc = pos_shifted[3:0];
  end

  // Measurement FSM: next state, counter control and frame completion
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    pcnt_d   = pcnt_q;
    wheld_d  = wheld_q;
    width_d  = width_q;
    period_d = period_q;
    pos_d    = pos_q;
    valid_d  = 1'b0;
    werr_d   = werr_q;
    perr_d   = perr_q;
    lost_d   = lost_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_q) begin
          wcnt_d  = '0;
          pcnt_d  = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        wcnt_d = wcnt_inc;
        pcnt_d = pcnt_inc;
        if (fall_q) begin
          wheld_d = wcnt_inc;
          state_d = ST_LOW;
        end else if (timeout) begin
          lost_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        pcnt_d = pcnt_inc;
        if (rise_q) begin
          width_d  = wheld_q;
          period_d = pcnt_inc;
          werr_d   = werr_calc;
          perr_d   = perr_calc;
          if (!werr_calc && !perr_calc) begin
            valid_d = 1'b1;
            lost_d  = 1'b0;
            pos_d   = pos_calc;
          end
          wcnt_d  = '0;
          pcnt_d  = '0;
          state_d = ST_HIGH;
        end else if (timeout) begin
          lost_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state registers; asynchronous reset discards any partial measurement
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sync_q   <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      presc_q  <= '0;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      wheld_q  <= '0;
      width_q  <= '0;
      period_q <= '0;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      werr_q   <= 1'b0;
      perr_q   <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      presc_q  <= presc_d;
      wcnt_q   <= wcnt_d;
      pcnt_q   <= pcnt_d;
      wheld_q  <= wheld_d;
      width_q  <= width_d;
      period_q <= period_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      werr_q   <= werr_d;
      perr_q   <= perr_d;
      lost_q   <= lost_d;
    end
  end

  assign Width_us   = width_q;
  assign Period_us  = period_q;
  assign Position   = pos_q;
  assign Valid      = valid_q;
  assign Width_Err  = werr_q;
  assign Period_Err = perr_q;
  assign Lost       = lost_q;

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// Bench for pwm_pulse_decoder with time constants scaled down so that whole
// pulse trains fit in a short run.
module tb_pwm_pulse_decoder;

  localparam int TD   = 2;    // sysclk cycles per tick
  localparam int PMIN = 40;   // width for position 0
  localparam int SH   = 2;
  localparam int WMN  = 20;
  localparam int WMX  = 120;
  localparam int PMN  = 150;
  localparam int PMX  = 400;
  localparam int TO   = 500;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        pin;
  logic [11:0] Width_us;
  logic [15:0] Period_us;
  logic [3:0]  Position;
  logic        Valid;
  logic        Width_Err;
  logic        Period_Err;
  logic        Lost;

  pwm_pulse_decoder #(
    .TICK_DIV      (TD),
    .POS_MIN_US    (PMIN),
    .POS_SHIFT     (SH),
    .WMIN_US       (WMN),
    .WMAX_US       (WMX),
    .PERIOD_MIN_US (PMN),
    .PERIOD_MAX_US (PMX),
    .TIMEOUT_US    (TO)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .Pulse_In   (pin),
    .Width_us   (Width_us),
    .Period_us  (Period_us),
    .Position   (Position),
    .Valid      (Valid),
    .Width_Err  (Width_Err),
    .Period_Err (Period_Err),
    .Lost       (Lost)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int h_us;
    int p_us;
    int xh;
    int xp;
    int pos;
    bit werr;
    bit perr;
  } vec_t;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: frame still being measured, and the expected outputs
  bit m_busy;
  int m_h, m_p;
  int e_w, e_p, e_pos;
  bit e_werr, e_perr, e_lost;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0;
    m_h = 0; m_p = 0;
    e_w = 0; e_p = 0; e_pos = 0;
    e_werr = 1'b0; e_perr = 1'b0; e_lost = 1'b1;
  endfunction

  // Closes the pending frame: microsecond values are plain floor division
  function automatic bit close_frame();
    int w, p, q;
    w = m_h / TD;
    p = m_p / TD;
    e_w = w;
    e_p = p;
    e_werr = (w < WMN) || (w > WMX);
    e_perr = (p < PMN) || (p > PMX);
    if (e_werr || e_perr) return 1'b0;
    if (w < PMIN) q = 0;
    else q = (w - PMIN) / (1 << SH);
    e_pos  = (q > 15) ? 15 : q;
    e_lost = 1'b0;
    return 1'b1;
  endfunction

  // One pin period: high for h cycles, period p cycles (rise to next rise).
  // Outputs produced by this rise are checked 4 cycles after the pin edge.
  task automatic pulse(input int h, input int p, input bit use_tab, input vec_t tv);
    bit ev;
    pin = 1'b1;
    for (int i = 1; i <= p; i++) begin
      @(negedge sysclk);
      if (i == 3 || i == 5) chk("valid_quiet", Valid, 0);
      if (i == 4) begin
        ev = m_busy ? close_frame() : 1'b0;
        chk("valid",      Valid,      ev);
        chk("width_us",   Width_us,   e_w);
        chk("period_us",  Period_us,  e_p);
        chk("position",   Position,   e_pos);
        chk("width_err",  Width_Err,  e_werr);
        chk("period_err", Period_Err, e_perr);
        chk("lost",       Lost,       e_lost);
        if (use_tab) begin
          chk("tab_width",  Width_us,   tv.h_us);
          chk("tab_period", Period_us,  tv.p_us);
          chk("tab_pos",    Position,   tv.pos);
          chk("tab_werr",   Width_Err,  tv.werr);
          chk("tab_perr",   Period_Err, tv.perr);
        end
      end
      if (p > TO * TD) begin
        if (i == 3 + TO * TD) chk("lost_before_timeout", Lost, e_lost);
        if (i == 4 + TO * TD) chk("lost_at_timeout", Lost, 1);
      end
      if (i == h) pin = 1'b0;
    end
    m_h = h;
    m_p = p;
    if (p > TO * TD) begin
      m_busy = 1'b0;
      e_lost = 1'b1;
    end else begin
      m_busy = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_width"},  Width_us,   0);
    chk({tag, "_period"}, Period_us,  0);
    chk({tag, "_pos"},    Position,   0);
    chk({tag, "_valid"},  Valid,      0);
    chk({tag, "_werr"},   Width_Err,  0);
    chk({tag, "_perr"},   Period_Err, 0);
    chk({tag, "_lost"},   Lost,       1);
  endtask

  vec_t tab[$];
  vec_t none;

  initial begin
    // h_us, p_us, extra high cycles, extra period cycles, position/errors of that frame
    tab.push_back('{60,  250, 0, 0, 5,  1'b0, 1'b0});
    tab.push_back('{60,  250, 1, 1, 5,  1'b0, 1'b0});
    tab.push_back('{36,  250, 0, 0, 0,  1'b0, 1'b0});
    tab.push_back('{104, 250, 0, 0, 15, 1'b0, 1'b0});
    tab.push_back('{103, 250, 0, 0, 15, 1'b0, 1'b0});
    tab.push_back('{130, 250, 0, 0, 15, 1'b1, 1'b0});
    tab.push_back('{60,  250, 0, 0, 5,  1'b0, 1'b0});
    tab.push_back('{60,  100, 0, 0, 5,  1'b0, 1'b1});
    tab.push_back('{120, 250, 0, 0, 15, 1'b0, 1'b0});
    tab.push_back('{121, 250, 0, 0, 15, 1'b1, 1'b0});
    tab.push_back('{20,  250, 0, 0, 0,  1'b0, 1'b0});
    tab.push_back('{19,  250, 0, 0, 0,  1'b1, 1'b0});
    tab.push_back('{44,  150, 0, 0, 1,  1'b0, 1'b0});
    tab.push_back('{43,  149, 0, 0, 1,  1'b0, 1'b1});
    tab.push_back('{60,  400, 0, 0, 5,  1'b0, 1'b0});
    tab.push_back('{60,  401, 0, 0, 5,  1'b0, 1'b1});
    tab.push_back('{40,  250, 0, 0, 0,  1'b0, 1'b0});
    tab.push_back('{60,  250, 0, 0, 5,  1'b0, 1'b0});
    none = tab[0];

    model_reset();
    pin   = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge sysclk);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (3) @(negedge sysclk);

    // Table: each frame is checked at the rise that closes it
    for (int i = 0; i < tab.size(); i++) begin
      pulse(tab[i].h_us * TD + tab[i].xh, tab[i].p_us * TD + tab[i].xp,
            (i > 0), (i > 0) ? tab[i-1] : none);
    end

    // Period of exactly TIMEOUT: the rise wins over the timeout
    pulse(60 * TD, TO * TD, 1'b0, none);
    pulse(60 * TD, 250 * TD, 1'b0, none);
    chk("boundary_perr", Period_Err, 1);
    pulse(60 * TD, 250 * TD, 1'b0, none);

    // Line held low well past the timeout, then two rises to recover
    pulse(60 * TD, 1125 * TD, 1'b0, none);
    pulse(60 * TD, 250 * TD, 1'b0, none);
    pulse(60 * TD, 250 * TD, 1'b0, none);
    pulse(60 * TD, 250 * TD, 1'b0, none);

    // One cycle past the timeout boundary
    pulse(60 * TD, TO * TD + 1, 1'b0, none);
    pulse(60 * TD, 250 * TD, 1'b0, none);
    pulse(60 * TD, 250 * TD, 1'b0, none);

    // Reset asserted partway into a high pulse
    pin = 1'b1;
    repeat (35 * TD) @(negedge sysclk);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge sysclk);
    pin = 1'b0;
    repeat (5) @(negedge sysclk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge sysclk);
    pulse(60 * TD, 250 * TD, 1'b0, none);
    pulse(90 * TD, 300 * TD, 1'b0, none);
    pulse(60 * TD, 250 * TD, 1'b0, none);

    // Randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      int h, p;
      h = int'($urandom_range(300, 20));
      p = int'($urandom_range(1040, 260));
      if (p < h + 6) p = h + 6;
      pulse(h, p, 1'b0, none);
    end
    pulse(60 * TD, 250 * TD, 1'b0, none);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
